shape_vertex_sequencer: RTL and testbench
=========================================

# shape_vertex_sequencer

Sequencer that streams one shape's vertices into the geometry pipeline. On a start request it drives the shape-select of the shape vertex LUT and snapshots the LUT's 12-vertex output. It then emits the shape's valid vertices one per valid/ready handshake, with index and last-vertex flag, toward the transform stage. It owns LUT sequencing, so the downstream pipeline only ever sees a clean vertex stream.

## Interface
- NUM_VERTS, 12, vertex slots supplied by the LUT
- COORD_W, 16, signed two's-complement width of each coordinate; vertex word = 3*COORD_W = {x, y, z}, x in MSBs
- clk  in  1  clock
- resetn  in  1  reset; one clock, asynchronous assert, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- shape_sel  in  2  shape to emit, captured with start
- stop  in  1  leave loop mode (FRAME_LOOP_EN only; ignored otherwise)
- frame_tick  in  1  per-frame pulse (FRAME_LOOP_EN only; ignored otherwise)
- lut_sel  out  2  to LUT shapeselect
- lut_v  in  NUM_VERTS*3*COORD_W  LUT vertices flattened, v0 in LSBs
- vtx_valid  out  1  vertex present
- vtx_ready  in  1  downstream accepts
- vtx_data  out  3*COORD_W  current vertex
- vtx_idx  out  4  index of current vertex, 0-based
- vtx_last  out  1  current vertex is final of pass
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after final handshake

## Operation
- Vertex count per shape, fixed: shape 0 = 4 (tetrahedron), 1 = 8, 2 = 12, 3 = 6.
- States: IDLE, LOAD, STREAM, DONE; plus WAIT_FRAME with FRAME_LOOP_EN.
- IDLE: start=1 latches shape_sel into the shape register and goes to LOAD. start in any other state is ignored.
- LOAD (1 cycle): lut_sel = latched shape, which is already driven from the register. Capture all of lut_v into a snapshot register and clear idx. Go to STREAM.
- STREAM: vtx_valid=1, vtx_data = snapshot[idx], vtx_last = (idx == count-1).
  - A handshake occurs when vtx_valid && vtx_ready. On a handshake, idx increments. On a handshake with last, go to DONE.
  - Data, idx and last stay stable while valid && !ready.
- DONE (1 cycle): done=1. Go to IDLE, or to WAIT_FRAME with FRAME_LOOP_EN.
- Later LUT or shape_sel changes do not affect an in-flight pass; the snapshot isolates it.
- idx never wraps, because it stops at count-1. Unused snapshot slots are never emitted.
- Reset values: state IDLE; lut_sel 0; idx 0; vtx_valid, vtx_last, busy and done all 0; vtx_data 0; snapshot 0.
- Reset asserted mid-stream drops vtx_valid immediately (asynchronously), and the pass is discarded.

## Timing
- start sampled at edge 0, LOAD during cycle 1, first vtx_valid in cycle 2.
- With vtx_ready tied high, a count-N pass emits in cycles 2..N+1, done is high in cycle N+2, and IDLE is reached in cycle N+3. Total start-to-done is N+2 cycles.
- The earliest next start is accepted in the first IDLE cycle.
- Outputs are registered or decoded from state and registers only, with no combinational path from vtx_ready to any output.

## Configuration
- FRAME_LOOP_EN defined: DONE goes to WAIT_FRAME (busy=1).
  - frame_tick goes to LOAD, re-snapshotting the LUT with the same latched shape.
  - stop in WAIT_FRAME goes to IDLE.
  - stop seen in any busy state is held in a sticky flag, so the current pass finishes, DONE pulses, then the block goes to IDLE.
  - If stop and frame_tick arrive in the same cycle, stop wins.
- FRAME_LOOP_EN undefined: single-pass only. stop and frame_tick are ignored, and the WAIT_FRAME logic is absent.

## Structure
- Shared gpu package holds:
  - COORD_W and NUM_VERTS
  - the shape ID constants (SHAPE_TETRA=0 …)
  - the shape-to-vertex-count constant function
  - the state encoding
- One sub-module is natural: vertex_snapshot_mux, which holds the snapshot register plus the idx-indexed 48-bit read mux. The FSM and counter stay in the top module.

## Test plan
- Reset, then start with shape_sel=0 and ready=1: 4 vertices at cycles 2–5, with idx 0..3 and last only on idx 3.
  - vertex 0 = {0000,0000,0330}
  - vertex 1 = {FFFF,FDBF,FCD0}
  - done at cycle 6, busy low at cycle 7.
- Shape 0 with ready toggling 1-0-1-0: vtx_data and idx are held across stalls, exactly 4 handshakes occur, and no vertex is duplicated or skipped.
- Change shape_sel and force lut_v to all-FFFF during STREAM: emitted data still matches the snapshot. A start pulse mid-stream is ignored, and busy stays high.
- Shape 2: 12 vertices, idx 0..11, last on idx 11, done at cycle 14.
- Assert resetn low at the 2nd handshake: vtx_valid, busy and done drop in the same cycle. After release the block is in IDLE, and a new start works normally.
- FRAME_LOOP_EN: after the first done, no output until frame_tick; each frame_tick yields a full pass with done. Stop during STREAM lets the pass finish, then the block reaches IDLE with no further passes.

Source files
------------

// File: rtl/shape_vertex_sequencer_pkg.sv
// Shared geometry constants: coordinate/vertex widths, shape IDs, vertex counts, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package shape_vertex_sequencer_pkg;

  localparam int COORD_W   = 16;
  localparam int NUM_VERTS = 12;
  localparam int VERT_W    = 3 * COORD_W;
  localparam int IDX_W     = 4;

  localparam logic [1:0] SHAPE_TETRA = 2'd0;
  localparam logic [1:0] SHAPE_CUBE  = 2'd1;
  localparam logic [1:0] SHAPE_ICOSA = 2'd2;
  localparam logic [1:0] SHAPE_OCTA  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_STREAM     = 3'd2,
    ST_DONE       = 3'd3,
    ST_WAIT_FRAME = 3'd4
  } state_e;

  // Number of valid LUT slots per shape; slots beyond this are never emitted.
  function automatic logic [IDX_W-1:0] shape_vert_count(input logic [1:0] shape);
    logic [IDX_W-1:0] cnt;
    case (shape)
      SHAPE_TETRA: cnt = 4'd4;
      SHAPE_CUBE:  cnt = 4'd8;
      SHAPE_ICOSA: cnt = 4'd12;
      default:     cnt = 4'd6;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/shape_vertex_sequencer_vertex_snapshot_mux.sv
// Snapshot register for all LUT vertices plus an index-driven read mux.
// Latency: snapshot captured on the clock edge ending a load cycle; read path is combinational from registers.
// Backpressure: none; holds its contents until the next load.
module vertex_snapshot_mux
  import shape_vertex_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        load_en,
  input  logic [NUM_VERTS*VERT_W-1:0] lut_v,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [VERT_W-1:0]           rd_dat
);

  logic [NUM_VERTS-1:0][VERT_W-1:0] snap_q, snap_d;

  // Next snapshot: take the whole LUT image on load, otherwise hold.
  always_comb begin
    snap_d = snap_q;
    if (load_en) begin
      for (int i = 0; i < NUM_VERTS; i++) begin
        snap_d[i] = lut_v[i*VERT_W +: VERT_W];
      end
    end
  end

  // Snapshot storage, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) snap_q <= '0;
    else         snap_q <= snap_d;
  end

  // Read mux; indices past the last slot read as zero rather than out of range.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_VERTS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_dat = snap_q[i];
    end
  end

endmodule

// File: rtl/shape_vertex_sequencer.sv
// Streams one shape's LUT vertices (snapshotted at start) as a valid/ready vertex stream with idx/last; optional FRAME_LOOP_EN macro repeats per frame_tick until stop.
// Latency: start -> LOAD 1 cycle -> first vertex next cycle; done pulses the cycle after the last handshake.
// Backpressure: vtx_data/idx/last held while vtx_valid && !vtx_ready; no combinational path from vtx_ready to outputs.
module shape_vertex_sequencer
  import shape_vertex_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [1:0]                  shape_sel,
  input  logic                        stop,
  input  logic                        frame_tick,
  output logic [1:0]                  lut_sel,
  input  logic [NUM_VERTS*VERT_W-1:0] lut_v,
  output logic                        vtx_valid,
  input  logic                        vtx_ready,
  output logic [VERT_W-1:0]           vtx_data,
  output logic [IDX_W-1:0]            vtx_idx,
  output logic                        vtx_last,
  output logic                        busy,
  output logic                        done
);

  state_e           state_q, state_d;
  logic [1:0]       shape_q, shape_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vert_cnt;
  logic             snap_load;

`ifdef FRAME_LOOP_EN
  logic stop_q, stop_d;
`else
  logic unused_loop_inputs;
  assign unused_loop_inputs = ^{stop, frame_tick};
`endif

  assign vert_cnt  = shape_vert_count(shape_q);
  assign lut_sel   = shape_q;
  assign vtx_valid = (state_q == ST_STREAM);
  assign vtx_idx   = idx_q;
  assign vtx_last  = (state_q == ST_STREAM) && (idx_q == vert_cnt - 4'd1);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // Next-state, shape capture and vertex index sequencing.
  always_comb begin
    state_d   = state_q;
    shape_d   = shape_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shape_d = shape_sel;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        snap_load = 1'b1;
        idx_d     = '0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (vtx_ready) begin
          // Index parks on the final slot so it can never wrap.
          if (vtx_last) state_d = ST_DONE;
          else          idx_d   = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
`ifdef FRAME_LOOP_EN
        if (stop_q || stop) state_d = ST_IDLE;
        else                state_d = ST_WAIT_FRAME;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef FRAME_LOOP_EN
      ST_WAIT_FRAME: begin
        // stop has priority over a coincident frame_tick.
        if (stop)            state_d = ST_IDLE;
        else if (frame_tick) state_d = ST_LOAD;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FRAME_LOOP_EN
  // Sticky stop request: lets the current pass finish, then exits the loop.
  always_comb begin
    stop_d = stop_q;
    if (state_q == ST_IDLE) stop_d = 1'b0;
    else if (stop)          stop_d = 1'b1;
  end

  // Sticky stop flag register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stop_q <= 1'b0;
    else         stop_q <= stop_d;
  end
`endif

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      shape_q <= 2'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shape_q <= shape_d;
      idx_q   <= idx_d;
    end
  end

  vertex_snapshot_mux u_snap (
    .clk     (clk),
    .resetn  (resetn),
    .load_en (snap_load),
    .lut_v   (lut_v),
    .rd_idx  (idx_q),
    .rd_dat  (vtx_data)
  );

endmodule

// File: tb/tb_shape_vertex_sequencer.sv
// Directed bench for shape_vertex_sequencer with an expected-vertex scoreboard.
// Stimulus pushes the expected vertex stream at start; a negedge monitor pops on each handshake.
// Timing checks use cycle numbers relative to the start-sampling edge (edge 0).
module tb_shape_vertex_sequencer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [1:0]   shape_sel;
  logic         stop;
  logic         frame_tick;
  logic [1:0]   lut_sel;
  logic [575:0] lut_v;
  logic         vtx_valid;
  logic         vtx_ready;
  logic [47:0]  vtx_data;
  logic [3:0]   vtx_idx;
  logic         vtx_last;
  logic         busy;
  logic         done;

  logic         lut_force;
  logic [52:0]  exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           hs_cnt = 0;
  int           edge_n = 0;
  int           start_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  shape_vertex_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .shape_sel  (shape_sel),
    .stop       (stop),
    .frame_tick (frame_tick),
    .lut_sel    (lut_sel),
    .lut_v      (lut_v),
    .vtx_valid  (vtx_valid),
    .vtx_ready  (vtx_ready),
    .vtx_data   (vtx_data),
    .vtx_idx    (vtx_idx),
    .vtx_last   (vtx_last),
    .busy       (busy),
    .done       (done)
  );

  // Hand-chosen LUT contents; shape 0 slots 0/1 are the reference tetrahedron vertices.
  function automatic logic [47:0] lut_word(input logic [1:0] s, input int i);
    logic [15:0] a, b, c;
    if (s == 2'd0 && i == 0) return 48'h0000_0000_0330;
    if (s == 2'd0 && i == 1) return 48'hFFFF_FDBF_FCD0;
    if (s == 2'd0 && i == 2) return 48'h0000_0240_FE68;
    if (s == 2'd0 && i == 3) return 48'h01C0_FF80_FE68;
    a = 16'(int'(s) * 4369 + i);
    b = 16'(32768 - i * 3);
    c = 16'(i * 257 + int'(s));
    return {a, b, c};
  endfunction

  function automatic int tb_count(input logic [1:0] s);
    case (s)
      2'd0: return 4;
      2'd1: return 8;
      2'd2: return 12;
      default: return 6;
    endcase
  endfunction

  // LUT model: answers whatever shape the DUT selects, or all-ones when forced.
  always_comb begin
    lut_v = '0;
    for (int i = 0; i < 12; i++) lut_v[i*48 +: 48] = lut_word(lut_sel, i);
    if (lut_force) lut_v = '1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && vtx_valid && vtx_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vertex: got idx=%0d data=%0h, expected no vertex", vtx_idx, vtx_data);
      end else begin
        chk("vertex", 64'({vtx_last, vtx_idx, vtx_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_exp(input logic [1:0] s);
    int n;
    n = tb_count(s);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 4'(i), lut_word(s, i)});
  endtask

  function automatic int cur_cycle();
    return edge_n - start_edge + 1;
  endfunction

  // Pulse start for one cycle; returns #1 into cycle 1.
  task automatic issue_start(input logic [1:0] s);
    @(posedge clk);
    #1;
    shape_sel = s;
    start = 1'b1;
    push_exp(s);
    @(posedge clk);
    #1;
    start = 1'b0;
    start_edge = edge_n;
  endtask

  task automatic to_cycle(input int k);
    while (cur_cycle() < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_cycle(input int k);
    to_cycle(k);
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL %s: done not seen within %0d cycles, expected a done pulse", nm, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [51:0] held;
    logic        hold_chk;
    logic        done_seen;
    int          hs0;

    resetn = 1'b0; start = 1'b0; shape_sel = 2'd0; stop = 1'b0;
    frame_tick = 1'b0; vtx_ready = 1'b1; lut_force = 1'b0;
    #1;
    chk("rst_valid", 64'(vtx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_last", 64'(vtx_last), 64'd0);
    chk("rst_idx_data", 64'({vtx_idx, vtx_data}), 64'd0);
    chk("rst_lut_sel", 64'(lut_sel), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Shape 0, ready high: exact cycle timing.
    issue_start(2'd0);
    at_cycle(1);
    chk("t1_load_busy", 64'(busy), 64'd1);
    chk("t1_load_valid", 64'(vtx_valid), 64'd0);
    at_cycle(2);
    chk("t1_first_valid", 64'(vtx_valid), 64'd1);
    at_cycle(5);
    chk("t1_last_c5", 64'({vtx_valid, vtx_last}), 64'b11);
    at_cycle(6);
    chk("t1_done_c6", 64'({done, vtx_valid}), 64'b10);
    at_cycle(7);
    chk("t1_idle_c7", 64'({busy, done}), 64'b00);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Shape 0, ready toggling: hold across stalls, exactly 4 handshakes.
    hs0 = hs_cnt;
    issue_start(2'd0);
    done_seen = 1'b0;
    hold_chk = 1'b0;
    held = '0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      @(posedge clk);
      #1;
      if (hold_chk) chk("t2_stall_hold", 64'({vtx_valid, vtx_idx, vtx_data}), 64'({1'b1, held}));
      vtx_ready = ~vtx_ready;
      hold_chk = !vtx_ready && vtx_valid;
      held = {vtx_idx, vtx_data};
      if (done) done_seen = 1'b1;
    end
    vtx_ready = 1'b1;
    chk("t2_done_seen", 64'(done_seen), 64'd1);
    chk("t2_hs_count", 64'(hs_cnt - hs0), 64'd4);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Shape 1: LUT and shape_sel disturbed mid-stream, start ignored.
    issue_start(2'd1);
    at_cycle(3);
    lut_force = 1'b1;
    shape_sel = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t3_busy_hold", 64'(busy), 64'd1);
    chk("t3_lut_sel", 64'(lut_sel), 64'd1);
    wait_done("t3_done", 30);
    lut_force = 1'b0;
    @(negedge clk);
    chk("t3_idle_after", 64'(busy), 64'd0);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // Shape 2: 12 vertices, done at cycle 14.
    issue_start(2'd2);
    at_cycle(13);
    chk("t4_last_c13", 64'({vtx_last, vtx_idx}), 64'({1'b1, 4'd11}));
    at_cycle(14);
    chk("t4_done_c14", 64'(done), 64'd1);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset at the second handshake, then a clean shape 3 pass.
    issue_start(2'd0);
    to_cycle(3);
    #1 resetn = 1'b0;
    #1;
    chk("t5_rst_drop", 64'({vtx_valid, busy, done}), 64'd0);
    chk("t5_q_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);
    issue_start(2'd3);
    at_cycle(8);
    chk("t5_done_c8", 64'(done), 64'd1);
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef FRAME_LOOP_EN
    issue_start(2'd0);
    wait_done("fl_first", 30);
    repeat (5) @(negedge clk);
    chk("fl_wait_quiet", 64'({busy, vtx_valid}), 64'b10);
    push_exp(2'd0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    wait_done("fl_tick1", 30);
    chk("fl_q_empty1", 64'(exp_q.size()), 64'd0);
    push_exp(2'd0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done("fl_stop_pass", 30);
    @(negedge clk);
    chk("fl_stop_idle", 64'(busy), 64'd0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("fl_no_more", 64'({busy, vtx_valid}), 64'd0);
    chk("fl_q_empty2", 64'(exp_q.size()), 64'd0);
`else
    @(posedge clk); #1 frame_tick = 1'b1; stop = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("sp_tick_ignored", 64'({busy, vtx_valid}), 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
